sar_adc_ctl: RTL and testbench

SAR_ADC_CTL -- requirements
Module: sar_adc_ctl

---
 rtl/sar_adc_ctl.sv | 177 +++++++++++++++++
 tb/tb_sar_adc_ctl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctl.sv
// sar_adc_ctl: successive-approximation ADC sequencer.
// Each conversion runs sample/hold reset, track, then ten SAR bit-steps, MSB first.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   start, abort    conversion request / cancel
//   ch_sel, settle  channel index and extra settle cycles, latched at start
//   comp_i          comparator result (1 = analog input above DAC)
//   dac1_en, dac1   DAC enable and SAR trial code
//   cmp_sel         one-hot comparator mux select
//   ad_rst, ad_hold sample/hold control
//   busy, done, err status; done and err are one-cycle pulses
//   result          code of the last completed conversion
//   result_ch       channel of the last completed conversion
// All outputs are registered.
module sar_adc_ctl #(
   parameter int unsigned RST_CYC = 2,
   parameter int unsigned NCH     = 18
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [4:0]     ch_sel,
   input  logic [3:0]     settle,
   input  logic           abort,
   input  logic           comp_i,
   output logic           dac1_en,
   output logic [9:0]     dac1,
   output logic [NCH-1:0] cmp_sel,
   output logic           ad_rst,
   output logic           ad_hold,
   output logic           busy,
   output logic           done,
   output logic [9:0]     result,
   output logic [4:0]     result_ch,
   output logic           err
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SHRST = 3'd1;
   localparam logic [2:0] TRACK = 3'd2;
   localparam logic [2:0] CONV  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [3:0] RST_LOAD = 4'(RST_CYC - 1);

   logic [2:0]     state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [3:0]     s_q, s_d;
   logic [4:0]     ch_q, ch_d;
   logic [3:0]     bit_q, bit_d;
   logic [9:0]     dac_d;
   logic [9:0]     result_d;
   logic [4:0]     result_ch_d;
   logic           err_d;
   logic [NCH-1:0] cmp_sel_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      s_d         = s_q;
      ch_d        = ch_q;
      bit_d       = bit_q;
      dac_d       = dac1;
      result_d    = result;
      result_ch_d = result_ch;
      err_d       = 1'b0;

      if (state_q != IDLE && abort) begin
         state_d = IDLE;
         dac_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               dac_d = '0;
               // abort in the same cycle suppresses the request entirely
               if (start && !abort) begin
                  if ({27'd0, ch_sel} < NCH) begin
                     state_d = SHRST;
                     ch_d    = ch_sel;
                     s_d     = settle;
                     cnt_d   = RST_LOAD;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            SHRST: begin
               if (cnt_q == 4'd0) begin
                  state_d = TRACK;
                  cnt_d   = s_q;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            TRACK: begin
               if (cnt_q == 4'd0) begin
                  state_d = CONV;
                  cnt_d   = s_q;
                  bit_d   = 4'd9;
                  dac_d   = 10'h200;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            CONV: begin
               if (cnt_q == 4'd0) begin
                  // last cycle of the bit-step: decide bit, then trial the next one
                  dac_d[bit_q] = comp_i;
                  if (bit_q == 4'd0) begin
                     state_d     = DONE;
                     result_d    = dac_d;
                     result_ch_d = ch_q;
                  end else begin
                     bit_d                = bit_q - 4'd1;
                     dac_d[bit_q - 4'd1] = 1'b1;
                     cnt_d                = s_q;
                  end
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            DONE: begin
               state_d = IDLE;
               dac_d   = '0;
            end
            default: begin
               state_d = IDLE;
               dac_d   = '0;
            end
         endcase
      end

      cmp_sel_d = '0;
      if (state_d != IDLE) begin
         cmp_sel_d[ch_d] = 1'b1;
      end
   end

   // Outputs are decoded from the next state so they stay flop outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         s_q       <= '0;
         ch_q      <= '0;
         bit_q     <= '0;
         dac1      <= '0;
         result    <= '0;
         result_ch <= '0;
         err       <= 1'b0;
         cmp_sel   <= '0;
         dac1_en   <= 1'b0;
         ad_rst    <= 1'b0;
         ad_hold   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s_q       <= s_d;
         ch_q      <= ch_d;
         bit_q     <= bit_d;
         dac1      <= dac_d;
         result    <= result_d;
         result_ch <= result_ch_d;
         err       <= err_d;
         cmp_sel   <= cmp_sel_d;
         dac1_en   <= (state_d != IDLE);
         ad_rst    <= (state_d == SHRST);
         ad_hold   <= (state_d == CONV);
         busy      <= (state_d != IDLE);
         done      <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_sar_adc_ctl.sv
// Self-checking bench for sar_adc_ctl: comparator model drives comp_i from an analog code,
// expected conversions are queued at start and checked when done pulses.
module tb_sar_adc_ctl;

   localparam int unsigned RST_CYC = 2;
   localparam int unsigned NCH     = 18;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [4:0]     ch_sel;
   logic [3:0]     settle;
   logic           abort;
   logic           comp_i;
   logic           dac1_en;
   logic [9:0]     dac1;
   logic [NCH-1:0] cmp_sel;
   logic           ad_rst;
   logic           ad_hold;
   logic           busy;
   logic           done;
   logic [9:0]     result;
   logic [4:0]     result_ch;
   logic           err;

   logic [9:0]  analog;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          done_seen = 0;
   int          adrst_seen = 0;
   logic [14:0] sb[$];
   logic [9:0]  last_result;
   logic [4:0]  last_ch;

   sar_adc_ctl #(.RST_CYC(RST_CYC), .NCH(NCH)) dut (
      .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .settle(settle), .abort(abort),
      .comp_i(comp_i), .dac1_en(dac1_en), .dac1(dac1), .cmp_sel(cmp_sel), .ad_rst(ad_rst),
      .ad_hold(ad_hold), .busy(busy), .done(done), .result(result), .result_ch(result_ch),
      .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (done) done_seen++;
      if (ad_rst) adrst_seen++;
   end

   assign comp_i = (analog >= dac1);

   // Drive a one-cycle start at a negedge; t0 counts from the cycle start is presented.
   task automatic kick(input logic [4:0] ch, input logic [3:0] s, output int t0);
      ch_sel = ch;
      settle = s;
      start  = 1'b1;
      t0     = cyc;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_result(input string name, input bit ok);
      logic [14:0] exp;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_timeout done never pulsed", name);
         sb.delete();
         return;
      end
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s_sb unexpected done result=%h", name, result);
         return;
      end
      exp = sb.pop_front();
      if (result !== exp[9:0]) begin
         failures++;
         $display("FAIL %s_result got=%h exp=%h", name, result, exp[9:0]);
      end
      checks++;
      if (result_ch !== exp[14:10]) begin
         failures++;
         $display("FAIL %s_result_ch got=%0d exp=%0d", name, result_ch, exp[14:10]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; ch_sel = '0; settle = '0; analog = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({dac1_en, dac1, cmp_sel, ad_rst, ad_hold, busy, done, result, result_ch, err} !== '0)
      begin
         failures++;
         $display("FAIL reset_outputs got dac1=%h cmp_sel=%h busy=%b result=%h exp all zero",
                  dac1, cmp_sel, busy, result);
      end
      rst = 1'b0;
      last_result = '0;
      last_ch = '0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int t0;
      bit ok;
      analog = 10'h2A5;
      sb.push_back({5'd7, 10'h2A5});
      kick(5'd7, 4'd0, t0);
      checks++;
      if ({busy, dac1_en, ad_rst, ad_hold} !== 4'b1110) begin
         failures++;
         $display("FAIL basic_shrst got busy/en/rst/hold=%b exp=1110", {busy, dac1_en, ad_rst, ad_hold});
      end
      checks++;
      if (cmp_sel !== 18'h00080) begin
         failures++;
         $display("FAIL basic_cmp_sel got=%h exp=00080", cmp_sel);
      end
      ch_sel = 5'd3;
      settle = 4'd9;
      repeat (2) @(negedge clk);
      checks++;
      if ({ad_rst, ad_hold} !== 2'b00) begin
         failures++;
         $display("FAIL basic_track got rst/hold=%b exp=00", {ad_rst, ad_hold});
      end
      @(negedge clk);
      checks++;
      if (ad_hold !== 1'b1 || dac1 !== 10'h200) begin
         failures++;
         $display("FAIL basic_conv_first got hold=%b dac1=%h exp hold=1 dac1=200", ad_hold, dac1);
      end
      wait_done(40, ok);
      checks++;
      if (cyc - t0 != 14) begin
         failures++;
         $display("FAIL basic_latency got=%0d exp=14", cyc - t0);
      end
      checks++;
      if (cmp_sel !== 18'h00080 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_done_state got cmp_sel=%h busy=%b exp 00080/1", cmp_sel, busy);
      end
      check_result("basic", ok);
      @(negedge clk);
      checks++;
      if ({busy, done, dac1_en} !== 3'b000 || cmp_sel !== '0 || dac1 !== '0) begin
         failures++;
         $display("FAIL basic_idle got busy=%b done=%b cmp_sel=%h dac1=%h exp zeros",
                  busy, done, cmp_sel, dac1);
      end
      last_result = 10'h2A5;
      last_ch = 5'd7;
   endtask

   task automatic test_settle();
      int t0;
      bit ok;
      analog = 10'h3FF;
      sb.push_back({5'd1, 10'h3FF});
      kick(5'd1, 4'd3, t0);
      wait_done(100, ok);
      checks++;
      if (cyc - t0 != 47) begin
         failures++;
         $display("FAIL settle_latency_hi got=%0d exp=47", cyc - t0);
      end
      check_result("settle_hi", ok);
      @(negedge clk);
      analog = 10'h000;
      sb.push_back({5'd2, 10'h000});
      kick(5'd2, 4'd3, t0);
      wait_done(100, ok);
      checks++;
      if (cyc - t0 != 47) begin
         failures++;
         $display("FAIL settle_latency_lo got=%0d exp=47", cyc - t0);
      end
      check_result("settle_lo", ok);
      @(negedge clk);
      last_result = 10'h000;
      last_ch = 5'd2;
   endtask

   task automatic test_bad_channel();
      ch_sel = 5'd18;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL badch_err got err=%b busy=%b exp err=1 busy=0", err, busy);
      end
      checks++;
      if (cmp_sel !== '0 || result !== last_result) begin
         failures++;
         $display("FAIL badch_state got cmp_sel=%h result=%h exp 0/%h", cmp_sel, result, last_result);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL badch_pulse got err=%b busy=%b exp 0/0", err, busy);
      end
   endtask

   task automatic test_abort();
      int t0;
      int ds;
      bit found;
      analog = 10'h0F0;
      kick(5'd5, 4'd0, t0);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (ad_hold && dac1[5] && dac1[4:0] == 5'd0) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL abort_reach bit-step 5 never seen dac1=%h", dac1);
      end
      ds = done_seen;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || cmp_sel !== '0 || dac1 !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle got busy=%b cmp_sel=%h dac1=%h done=%b exp zeros",
                  busy, cmp_sel, dac1, done);
      end
      checks++;
      if (result !== last_result || result_ch !== last_ch) begin
         failures++;
         $display("FAIL abort_keep got result=%h ch=%0d exp %h/%0d", result, result_ch,
                  last_result, last_ch);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (done_seen != ds) begin
         failures++;
         $display("FAIL abort_no_done got=%0d exp=0 done pulses", done_seen - ds);
      end
      ch_sel = 5'd3;
      start  = 1'b1;
      abort  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      abort  = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_start got busy=%b exp=0", busy);
      end
      @(negedge clk);
   endtask

   task automatic test_rst_mid();
      int t0;
      int ds;
      bit ok;
      analog = 10'h0AA;
      kick(5'd2, 4'd2, t0);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (busy && !ad_rst && !ad_hold) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rstmid_track TRACK phase never seen");
      end
      ds = done_seen;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({dac1_en, dac1, cmp_sel, ad_rst, ad_hold, busy, done, result, result_ch, err} !== '0)
      begin
         failures++;
         $display("FAIL rstmid_outputs got busy=%b cmp_sel=%h result=%h exp all zero",
                  busy, cmp_sel, result);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done_seen != ds) begin
         failures++;
         $display("FAIL rstmid_wait got busy=%b dones=%0d exp 0/0", busy, done_seen - ds);
      end
      analog = 10'h155;
      sb.push_back({5'd4, 10'h155});
      kick(5'd4, 4'd0, t0);
      wait_done(40, ok);
      check_result("rstmid", ok);
      @(negedge clk);
      last_result = 10'h155;
      last_ch = 5'd4;
   endtask

   task automatic test_back_to_back();
      int ds;
      int ar;
      bit ok;
      analog = 10'h1C3;
      ds = done_seen;
      ar = adrst_seen;
      sb.push_back({5'd9, 10'h1C3});
      sb.push_back({5'd9, 10'h1C3});
      ch_sel = 5'd9;
      settle = 4'd1;
      start  = 1'b1;
      wait_done(60, ok);
      check_result("b2b_first", ok);
      wait_done(60, ok);
      check_result("b2b_second", ok);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (done_seen - ds != 2) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d exp=2", done_seen - ds);
      end
      checks++;
      if (adrst_seen - ar != 2 * RST_CYC) begin
         failures++;
         $display("FAIL b2b_adrst_cycles got=%0d exp=%0d", adrst_seen - ar, 2 * RST_CYC);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_settle();
      test_bad_channel();
      test_abort();
      test_rst_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout bench did not complete");
      $fatal(1);
   end

endmodule
